// File: rtl/fetch_queue_unit.sv
// Sequential instruction fetch with credit-limited requests, an in-order response FIFO
// feeding decode, and redirect handling that drains stale in-flight responses.
module fetch_queue_unit #(
    parameter int unsigned instructionWidth = 32,
    parameter int unsigned addressSize      = 64,
    parameter int unsigned queueDepth       = 4,
    parameter int unsigned queueIndexWidth  = 2,
    parameter logic [addressSize-1:0] resetVector = 64'h0
) (
    input  logic                        clock_i,
    input  logic                        reset_i,
    input  logic                        enable_i,
    input  logic                        redirect_i,
    input  logic [addressSize-1:0]      redirectAddress_i,
    output logic                        memReq_o,
    input  logic                        memReady_i,
    output logic [addressSize-1:0]      memAddress_o,
    input  logic                        memValid_i,
    input  logic [instructionWidth-1:0] memInstruction_i,
    input  logic                        decodeReady_i,
    output logic [instructionWidth-1:0] instruction_o,
    output logic [addressSize-1:0]      instructionAddress_o,
    output logic                        instructionValid_o
);

    localparam int unsigned CntW = queueIndexWidth + 1;
    localparam int unsigned SumW = queueIndexWidth + 2;
    localparam logic [SumW-1:0]            DepthSum  = SumW'(queueDepth);
    localparam logic [addressSize-1:0]     AlignMask = ~addressSize'(3);
    localparam logic [addressSize-1:0]     PcStep    = addressSize'(4);
    localparam logic [addressSize-1:0]     ResetPc   = resetVector & AlignMask;
    localparam logic [queueIndexWidth-1:0] PtrOne    = queueIndexWidth'(1);

    typedef enum logic {StRun, StDrain} state_e;

    state_e                      r_state;
    logic [addressSize-1:0]      r_fetch_pc;
    logic [addressSize-1:0]      r_resp_pc;
    logic [CntW-1:0]             r_in_flight;
    logic [CntW-1:0]             r_occupancy;
    logic [queueIndexWidth-1:0]  r_rd_ptr;
    logic [queueIndexWidth-1:0]  r_wr_ptr;
    logic [instructionWidth-1:0] r_data [queueDepth];
    logic [addressSize-1:0]      r_addr [queueDepth];

    logic                   w_credit;
    logic                   w_mem_req;
    logic                   w_fire;
    logic                   w_resp;
    logic                   w_enq;
    logic                   w_valid;
    logic                   w_deq;
    logic [CntW-1:0]        w_in_flight_d;
    logic [addressSize-1:0] w_redirect_pc;

    // Queued plus outstanding words never exceed the FIFO, so a response always has a slot
    assign w_credit  = ({1'b0, r_occupancy} + {1'b0, r_in_flight}) < DepthSum;
    assign w_mem_req = !reset_i && (r_state == StRun) && enable_i && !redirect_i && w_credit;
    assign w_fire    = w_mem_req && memReady_i;
    // A response with nothing outstanding is a protocol error and is dropped entirely
    assign w_resp    = memValid_i && (r_in_flight != '0);
    assign w_enq     = w_resp && (r_state == StRun) && !redirect_i;
    assign w_valid   = r_occupancy != '0;
    assign w_deq     = w_valid && decodeReady_i && enable_i;

    assign w_in_flight_d = r_in_flight + CntW'(w_fire) - CntW'(w_resp);
    assign w_redirect_pc = redirectAddress_i & AlignMask;

    assign memReq_o             = w_mem_req;
    assign memAddress_o         = reset_i ? '0 : r_fetch_pc;
    assign instructionValid_o   = w_valid;
    assign instruction_o        = w_valid ? r_data[r_rd_ptr] : '0;
    assign instructionAddress_o = w_valid ? r_addr[r_rd_ptr] : '0;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_state     <= StRun;
            r_fetch_pc  <= ResetPc;
            r_resp_pc   <= ResetPc;
            r_in_flight <= '0;
            r_occupancy <= '0;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            for (int i = 0; i < queueDepth; i++) begin
                r_data[i] <= '0;
                r_addr[i] <= '0;
            end
        end else begin
            r_in_flight <= w_in_flight_d;
            if (redirect_i) begin
                r_fetch_pc  <= w_redirect_pc;
                r_resp_pc   <= w_redirect_pc;
                r_occupancy <= '0;
                r_rd_ptr    <= '0;
                r_wr_ptr    <= '0;
                r_state     <= (w_in_flight_d != '0) ? StDrain : StRun;
            end else begin
                if (w_fire) begin
                    r_fetch_pc <= r_fetch_pc + PcStep;
                end
                if (w_enq) begin
                    r_data[r_wr_ptr] <= memInstruction_i;
                    r_addr[r_wr_ptr] <= r_resp_pc;
                    r_wr_ptr         <= r_wr_ptr + PtrOne;
                    r_resp_pc        <= r_resp_pc + PcStep;
                end
                if (w_deq) begin
                    r_rd_ptr <= r_rd_ptr + PtrOne;
                end
                r_occupancy <= r_occupancy + CntW'(w_enq) - CntW'(w_deq);
                if ((r_state == StDrain) && (w_in_flight_d == '0)) begin
                    r_state <= StRun;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: directed scenarios plus random traffic against a queue-level
// reference model and an in-order variable-latency memory.
module tb_fetch_queue_unit;

    logic        clock_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        enable_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [63:0] redirectAddress_i = '0;
    logic        memReq_o;
    logic        memReady_i = 1'b0;
    logic [63:0] memAddress_o;
    logic        memValid_i = 1'b0;
    logic [31:0] memInstruction_i = '0;
    logic        decodeReady_i = 1'b0;
    logic [31:0] instruction_o;
    logic [63:0] instructionAddress_o;
    logic        instructionValid_o;

    fetch_queue_unit dut (
        .clock_i              (clock_i),
        .reset_i              (reset_i),
        .enable_i             (enable_i),
        .redirect_i           (redirect_i),
        .redirectAddress_i    (redirectAddress_i),
        .memReq_o             (memReq_o),
        .memReady_i           (memReady_i),
        .memAddress_o         (memAddress_o),
        .memValid_i           (memValid_i),
        .memInstruction_i     (memInstruction_i),
        .decodeReady_i        (decodeReady_i),
        .instruction_o        (instruction_o),
        .instructionAddress_o (instructionAddress_o),
        .instructionValid_o   (instructionValid_o)
    );

    always #5 clock_i = ~clock_i;

    typedef struct packed {logic [63:0] addr; logic [31:0] data;} ent_t;
    typedef struct packed {logic [63:0] addr; int due;} req_t;

    ent_t        mq[$];
    req_t        pend[$];
    int          m_inflight;
    logic [63:0] m_fetch;
    logic [63:0] m_resp;
    bit          m_drain;
    int          cyc = 0;
    int          last_due;
    int          lat_min = 1;
    int          lat_max = 1;
    int          fires_seen;
    logic [63:0] first_fire_addr;
    bit          stray = 1'b0;
    int          errors = 0;
    int          checks = 0;

    function automatic logic [31:0] word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'hC0DE_0001 ^ {a[9:2], 24'h0};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        pend.delete();
        m_inflight = 0;
        m_fetch    = 64'h0;
        m_resp     = 64'h0;
        m_drain    = 1'b0;
        last_due   = -1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_req"}, 64'(memReq_o), 64'h0);
        chk({tag, "_addr"}, memAddress_o, 64'h0);
        chk({tag, "_valid"}, 64'(instructionValid_o), 64'h0);
        chk({tag, "_instr"}, 64'(instruction_o), 64'h0);
        chk({tag, "_iaddr"}, instructionAddress_o, 64'h0);
    endtask

    task automatic do_reset();
        @(negedge clock_i);
        reset_i = 1'b1;
        enable_i = 1'b0; redirect_i = 1'b0; memValid_i = 1'b0;
        memReady_i = 1'b0; decodeReady_i = 1'b0;
        #1;
        chk_zero("reset");
        @(negedge clock_i);
        reset_i = 1'b0;
        model_reset();
    endtask

    // Look at registered state right after the coming clock edge
    task automatic peek();
        @(posedge clock_i);
        #1;
    endtask

    task automatic cycle(input logic en, input logic mrdy, input logic drdy,
                         input logic redir, input logic [63:0] raddr);
        logic        e_req, fire, resp, deq;
        logic [63:0] e_instr, e_iaddr;
        int          due;
        @(negedge clock_i);
        enable_i = en; memReady_i = mrdy; decodeReady_i = drdy;
        redirect_i = redir; redirectAddress_i = raddr;
        if (stray) begin
            memValid_i = 1'b1; memInstruction_i = 32'hDEAD_BEEF; stray = 1'b0;
        end else if (pend.size() != 0 && pend[0].due <= cyc) begin
            memValid_i = 1'b1; memInstruction_i = word(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            memValid_i = 1'b0; memInstruction_i = $urandom;
        end
        #1;
        e_req = !m_drain && en && !redir && (mq.size() + m_inflight < 4);
        e_instr = 64'h0;
        e_iaddr = 64'h0;
        if (mq.size() != 0) begin
            e_instr = 64'(mq[0].data);
            e_iaddr = mq[0].addr;
        end
        chk("mem_req", 64'(memReq_o), 64'(e_req));
        chk("mem_addr", memAddress_o, m_fetch);
        chk("instr_valid", 64'(instructionValid_o), 64'(mq.size() != 0));
        chk("instr", 64'(instruction_o), e_instr);
        chk("instr_addr", instructionAddress_o, e_iaddr);
        if (memReq_o === 1'b1 && memReady_i) begin
            fires_seen++;
            if (fires_seen == 1) first_fire_addr = memAddress_o;
        end
        fire = e_req && mrdy;
        resp = memValid_i && (m_inflight > 0);
        deq  = (mq.size() != 0) && drdy && en;
        if (fire) begin
            due = cyc + $urandom_range(lat_max, lat_min);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend.push_back('{addr: m_fetch, due: due});
        end
        if (redir) begin
            mq.delete();
            m_fetch = {raddr[63:2], 2'b00};
            m_resp  = m_fetch;
            m_inflight = m_inflight - (resp ? 1 : 0);
            m_drain = (m_inflight != 0);
        end else begin
            if (deq) void'(mq.pop_front());
            if (resp && !m_drain) begin
                mq.push_back('{addr: m_resp, data: memInstruction_i});
                m_resp = m_resp + 64'd4;
            end
            if (fire) m_fetch = m_fetch + 64'd4;
            m_inflight = m_inflight + (fire ? 1 : 0) - (resp ? 1 : 0);
            if (m_drain && m_inflight == 0) m_drain = 1'b0;
        end
        cyc++;
    endtask

    initial begin
        model_reset();
        do_reset();

        // Streaming with single-cycle memory
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 64'h0);

        // Decode stalled: credit limit caps requests at the queue depth
        do_reset();
        fires_seen = 0;
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 64'h0);
        chk("fill_fires", 64'(fires_seen), 64'd4);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 64'h0);

        // Redirect with three requests outstanding
        do_reset();
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 64'h0);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 64'h1000);
        peek();
        chk("redir_addr", memAddress_o, 64'h1000);
        chk("redir_empty", 64'(instructionValid_o), 64'h0);
        fires_seen = 0; first_fire_addr = 64'h0;
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 64'h0);
        chk("redir_first_fetch", first_fire_addr, 64'h1000);

        // Unaligned redirect, then a second redirect while draining
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 64'h2003);
        peek();
        chk("unaligned_redir", memAddress_o, 64'h2000);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 64'h3000);
        peek();
        chk("drain_redir", memAddress_o, 64'h3000);
        fires_seen = 0; first_fire_addr = 64'h0;
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 64'h0);
        chk("drain_first_fetch", first_fire_addr, 64'h3000);

        // Enable low: responses still land, nothing issued or dequeued
        do_reset();
        for (int i = 0; i < 2; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 64'h0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
        peek();
        chk("disabled_valid", 64'(instructionValid_o), 64'h1);
        chk("disabled_head", instructionAddress_o, 64'h0);

        // Asynchronous reset between edges, then a stray response
        do_reset();
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 64'h0);
        #1 reset_i = 1'b1;
        #1 chk_zero("midreset");
        enable_i = 1'b0; redirect_i = 1'b0; memValid_i = 1'b0;
        memReady_i = 1'b0; decodeReady_i = 1'b0;
        @(negedge clock_i);
        reset_i = 1'b0;
        model_reset();
        stray = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 64'h0);

        // Random traffic, starting near the top of the address space
        lat_min = 1; lat_max = 4;
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF6);
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom % 10) != 0, ($urandom % 4) != 0, ($urandom % 3) != 0,
                  ($urandom % 25) == 0, {$urandom, $urandom});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
